// File: rtl/cic_filter.sv
// CIC rate-change filter: decimator (DnI=1) or interpolator (DnI=0), with
// the output normalised by RATE**STAGES so that a DC input reappears unchanged.
module cic_filter #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int RATE   = 4,
    parameter int DnI    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    localparam int LOG2R = $clog2(RATE);
    localparam int IW    = WIDTH + STAGES * LOG2R;
    localparam logic [LOG2R-1:0] STROBE_PHASE = (DnI != 0) ? LOG2R'(RATE - 1) : '0;

    logic [LOG2R-1:0] phase_q;
    logic             strobe;
    logic [IW-1:0]    in_ext;
    logic [IW-1:0]    integ_src;
    logic [IW-1:0]    comb_src;
    logic [IW-1:0]    integ_q [STAGES];
    logic [IW-1:0]    integ_d [STAGES];
    logic [IW-1:0]    dly_q   [STAGES];
    logic [IW-1:0]    dly_d   [STAGES];
    logic [IW-1:0]    comb_c  [STAGES+1];

    assign strobe = (phase_q == STROBE_PHASE);
    assign in_ext = {{(IW-WIDTH){1'b0}}, in};

    // Modular arithmetic throughout: integrator wrap cancels in the combs.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign integ_d[gi] = integ_q[gi] + integ_src;
            end else begin : g_next
                assign integ_d[gi] = integ_q[gi] + integ_q[gi-1];
            end
            assign comb_c[gi+1] = comb_c[gi] - dly_q[gi];
            assign dly_d[gi]    = strobe ? comb_c[gi] : dly_q[gi];
        end
    endgenerate

    assign comb_c[0] = comb_src;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            phase_q <= phase_q + 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

    generate
        if (DnI != 0) begin : g_dec
            logic [WIDTH-1:0] out_q;

            assign integ_src = in_ext;
            assign comb_src  = integ_q[STAGES-1];

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    out_q <= '0;
                end else if (strobe) begin
                    out_q <= comb_c[STAGES][IW-1 -: WIDTH];
                end
            end

            assign out = out_q;
        end else begin : g_int
            // Comb result held for RATE cycles: zero-order-hold upsampling.
            logic [IW-1:0] cr_q;

            assign integ_src = cr_q;
            assign comb_src  = in_ext;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cr_q <= '0;
                end else if (strobe) begin
                    cr_q <= comb_c[STAGES];
                end
            end

            assign out = integ_q[STAGES-1][IW-1 -: WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_cic_filter.sv
// Bench for cic_filter: decimator and interpolator side by side, each checked
// cycle by cycle against a direct-convolution impulse-response model.
module tb_cic_filter;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int R  = 4;
    localparam int IW = W + N * 2;
    localparam int LD = N * (R - 1) + 1;        // decimator impulse length
    localparam int LI = (N + 1) * (R - 1) + 1;  // interpolator impulse length

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] in_dec, in_int, out_dec, out_int;

    always #5 clk = ~clk;

    cic_filter #(.WIDTH(W), .STAGES(N), .RATE(R), .DnI(1)) u_dec (
        .clk  (clk),
        .rstn (rstn),
        .in   (in_dec),
        .out  (out_dec)
    );

    cic_filter #(.WIDTH(W), .STAGES(N), .RATE(R), .DnI(0)) u_int (
        .clk  (clk),
        .rstn (rstn),
        .in   (in_int),
        .out  (out_int)
    );

    typedef struct {
        longint dec;
        longint itp;
    } exp_t;

    int     checks   = 0;
    int     failures = 0;
    int     ecnt     = 0;
    longint last_dec = 0;
    longint hd [LD];
    longint hi [LI];
    longint xd [2048];
    longint xi [2048];
    exp_t   sb_q [$];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, ecnt, obs, exp);
        end
    endtask

    // Impulse responses: k-fold convolution of length-R boxcars.
    task automatic build_h();
        longint h [64];
        longint t [64];
        int     len = 1;
        for (int i = 0; i < 64; i++) h[i] = 0;
        h[0] = 1;
        for (int k = 1; k <= N + 1; k++) begin
            for (int i = 0; i < 64; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++)
                    t[i+j] += h[i];
            len += R - 1;
            for (int i = 0; i < 64; i++) h[i] = t[i];
            if (k == N)     for (int i = 0; i < LD; i++) hd[i] = h[i];
            if (k == N + 1) for (int i = 0; i < LI; i++) hi[i] = h[i];
        end
    endtask

    function automatic longint top_bits(input longint full);
        longint mask = (longint'(1) << IW) - 1;
        return (full & mask) >> (IW - W);
    endfunction

    // Value after edge e: sample taken at edge s contributes h[e-N-s].
    function automatic longint model_out(input bit dec, input int e);
        longint acc = 0;
        for (int s = 0; s <= e - N; s++) begin
            int j = e - N - s;
            if (dec && j < LD) acc += xd[s] * hd[j];
            if (!dec && j < LI && (s % R) == 0) acc += xi[s] * hi[j];
        end
        return top_bits(acc);
    endfunction

    task automatic step(input logic [W-1:0] dv, input logic [W-1:0] iv);
        exp_t ex;
        in_dec = dv;
        if ((ecnt % R) == 0) in_int = iv;
        xd[ecnt] = longint'(in_dec);
        xi[ecnt] = longint'(in_int);
        if ((ecnt % R) == R - 1) last_dec = model_out(1'b1, ecnt);
        ex.dec = last_dec;
        ex.itp = model_out(1'b0, ecnt);
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check_val("dec_out", longint'(out_dec), ex.dec);
        check_val("int_out", longint'(out_int), ex.itp);
        ecnt++;
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_val("rst_dec", longint'(out_dec), 0);
            check_val("rst_int", longint'(out_int), 0);
        end
        rstn     = 1'b1;
        ecnt     = 0;
        last_dec = 0;
        sb_q.delete();
    endtask

    initial begin
        build_h();
        rstn   = 1'b0;
        in_dec = '0;
        in_int = '0;

        do_reset(3);
        repeat (8) step(8'd0, 8'd0);
        $display("segment reset_zero: out_dec=%0d out_int=%0d", out_dec, out_int);

        for (int c = 0; c < 40; c++) begin
            step(8'd100, 8'd60);
            if (c == 18) check_val("dc_dec_19", longint'(out_dec), 100);
        end
        check_val("dc_dec", longint'(out_dec), 100);
        check_val("dc_int", longint'(out_int), 60);
        $display("segment dc: out_dec=%0d out_int=%0d", out_dec, out_int);

        do_reset(1);
        for (int c = 0; c < 40; c++)
            step(((ecnt % 2) != 0) ? 8'd200 : 8'd0, 8'd255);
        check_val("null_dec", longint'(out_dec), 100);
        check_val("fs_int", longint'(out_int), 255);
        $display("segment fs2_null: out_dec=%0d out_int=%0d", out_dec, out_int);

        for (int c = 0; c < 40; c++) step(8'd255, 8'd60);
        check_val("fs_dec", longint'(out_dec), 255);
        check_val("dc2_int", longint'(out_int), 60);
        $display("segment full_scale: out_dec=%0d out_int=%0d", out_dec, out_int);

        for (int c = 0; c < 30; c++) step(8'd0, 8'd0);
        check_val("zero_dec", longint'(out_dec), 0);
        for (int c = 0; c < 30; c++) begin
            step(8'd200, 8'd200);
            if (c == 18) check_val("step_dec_19", longint'(out_dec), 200);
        end
        check_val("step_dec", longint'(out_dec), 200);
        check_val("step_int", longint'(out_int), 200);
        $display("segment step: out_dec=%0d out_int=%0d", out_dec, out_int);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
